// File: rtl/lsq_issue_buffer.sv
// In-order load/store issue queue: captures CDB operands, issues the head op to the LSU
// when ready, and holds load results on the CDB request until the arbiter grants.
module lsq_issue_buffer #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     disp_valid,
  output logic                     disp_ready,
  input  logic [2:0]               disp_op,
  input  logic [31:0]              disp_offset,
  input  logic [31:0]              disp_base_val,
  input  logic [TAG_W-1:0]         disp_base_tag,
  input  logic                     disp_base_rdy,
  input  logic [31:0]              disp_data_val,
  input  logic [TAG_W-1:0]         disp_data_tag,
  input  logic                     disp_data_rdy,
  input  logic [TAG_W-1:0]         disp_dest_tag,
  input  logic                     cdb_in_valid,
  input  logic [TAG_W-1:0]         cdb_in_tag,
  input  logic [31:0]              cdb_in_value,
  output logic [31:0]              lsu_base_addr,
  output logic [31:0]              lsu_offset,
  output logic [31:0]              lsu_store_data,
  output logic [2:0]               lsu_mem_op,
  output logic                     lsu_mem_req,
  input  logic                     lsu_ready,
  input  logic [31:0]              lsu_load_data,
  output logic                     cdb_req,
  output logic [TAG_W-1:0]         cdb_tag,
  output logic [31:0]              cdb_value,
  input  logic                     cdb_grant,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [2:0]       op;
    logic [31:0]      offset;
    logic [31:0]      base_val;
    logic [TAG_W-1:0] base_tag;
    logic             base_rdy;
    logic [31:0]      data_val;
    logic [TAG_W-1:0] data_tag;
    logic             data_rdy;
    logic [TAG_W-1:0] dest_tag;
  } entry_t;

  typedef enum logic {IDLE, WAIT_CDB} state_t;

  entry_t           ent [DEPTH];
  logic [DEPTH-1:0] vld;
  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;
  logic [CW-1:0]    cnt;
  state_t           state;

  logic   head_rdy;
  logic   issue;
  logic   pop;
  logic   enq;
  entry_t new_ent;

  assign head_rdy = ent[head].base_rdy && (!ent[head].op[2] || ent[head].data_rdy);
  assign issue    = rst && (state == IDLE) && vld[head] && head_rdy && lsu_ready && !flush;
  assign pop      = !flush && ((issue && ent[head].op[2]) || ((state == WAIT_CDB) && cdb_grant));
  assign disp_ready = (cnt < CW'(DEPTH)) && !flush;
  assign enq      = disp_valid && disp_ready;

  // A producer broadcasting in the dispatch cycle is forwarded straight into the new entry.
  always_comb begin
    new_ent          = '0;
    new_ent.op       = disp_op;
    new_ent.offset   = disp_offset;
    new_ent.base_val = disp_base_val;
    new_ent.base_tag = disp_base_tag;
    new_ent.base_rdy = disp_base_rdy;
    new_ent.data_val = disp_data_val;
    new_ent.data_tag = disp_data_tag;
    new_ent.data_rdy = disp_data_rdy;
    new_ent.dest_tag = disp_dest_tag;
    if (cdb_in_valid && !disp_base_rdy && (disp_base_tag == cdb_in_tag)) begin
      new_ent.base_val = cdb_in_value;
      new_ent.base_rdy = 1'b1;
    end
    if (cdb_in_valid && !disp_data_rdy && (disp_data_tag == cdb_in_tag)) begin
      new_ent.data_val = cdb_in_value;
      new_ent.data_rdy = 1'b1;
    end
  end

  assign lsu_base_addr  = ent[head].base_val;
  assign lsu_offset     = ent[head].offset;
  assign lsu_store_data = ent[head].data_val;
  assign lsu_mem_op     = ent[head].op;
  assign lsu_mem_req    = issue;
  assign cdb_req        = (state == WAIT_CDB);
  assign cdb_tag        = ent[head].dest_tag;
  assign count          = cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
      vld       <= '0;
      head      <= '0;
      tail      <= '0;
      cnt       <= '0;
      state     <= IDLE;
      cdb_value <= '0;
    end else if (flush) begin
      vld   <= '0;
      head  <= '0;
      tail  <= '0;
      cnt   <= '0;
      state <= IDLE;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (vld[i] && cdb_in_valid) begin
          if (!ent[i].base_rdy && (ent[i].base_tag == cdb_in_tag)) begin
            ent[i].base_val <= cdb_in_value;
            ent[i].base_rdy <= 1'b1;
          end
          if (!ent[i].data_rdy && (ent[i].data_tag == cdb_in_tag)) begin
            ent[i].data_val <= cdb_in_value;
            ent[i].data_rdy <= 1'b1;
          end
        end
      end
      // head==tail only when empty or full, so enqueue and pop never touch the same slot.
      if (enq) begin
        ent[tail] <= new_ent;
        vld[tail] <= 1'b1;
        tail      <= tail + PW'(1);
      end
      if (pop) begin
        vld[head] <= 1'b0;
        head      <= head + PW'(1);
      end
      cnt <= cnt + CW'(enq) - CW'(pop);
      case (state)
        IDLE: begin
          if (issue && !ent[head].op[2]) begin
            cdb_value <= lsu_load_data;
            state     <= WAIT_CDB;
          end
        end
        WAIT_CDB: begin
          if (cdb_grant) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsq_issue_buffer.sv
// Directed and randomized checks of lsq_issue_buffer against a queue-based reference model.
module tb_lsq_issue_buffer;
  localparam int DEPTH = 4;
  localparam int TAG_W = 4;

  logic clk = 1'b0;
  logic rst, flush, disp_valid, disp_ready, disp_base_rdy, disp_data_rdy;
  logic [2:0] disp_op, lsu_mem_op;
  logic [31:0] disp_offset, disp_base_val, disp_data_val, cdb_in_value;
  logic [TAG_W-1:0] disp_base_tag, disp_data_tag, disp_dest_tag, cdb_in_tag, cdb_tag;
  logic cdb_in_valid, lsu_mem_req, lsu_ready, cdb_req, cdb_grant;
  logic [31:0] lsu_base_addr, lsu_offset, lsu_store_data, lsu_load_data, cdb_value;
  logic [$clog2(DEPTH):0] count;

  always #5 clk = ~clk;

  lsq_issue_buffer #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .flush(flush), .disp_valid(disp_valid), .disp_ready(disp_ready),
    .disp_op(disp_op), .disp_offset(disp_offset), .disp_base_val(disp_base_val),
    .disp_base_tag(disp_base_tag), .disp_base_rdy(disp_base_rdy), .disp_data_val(disp_data_val),
    .disp_data_tag(disp_data_tag), .disp_data_rdy(disp_data_rdy), .disp_dest_tag(disp_dest_tag),
    .cdb_in_valid(cdb_in_valid), .cdb_in_tag(cdb_in_tag), .cdb_in_value(cdb_in_value),
    .lsu_base_addr(lsu_base_addr), .lsu_offset(lsu_offset), .lsu_store_data(lsu_store_data),
    .lsu_mem_op(lsu_mem_op), .lsu_mem_req(lsu_mem_req), .lsu_ready(lsu_ready),
    .lsu_load_data(lsu_load_data), .cdb_req(cdb_req), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
    .cdb_grant(cdb_grant), .count(count)
  );

  typedef struct {
    logic [2:0]  op;
    logic [31:0] off, base, data;
    logic [3:0]  btag, dtag, dest;
    bit          brdy, drdy;
  } m_ent_t;

  m_ent_t q[$];
  bit m_wait;
  logic [31:0] m_val;
  int checks = 0;
  int passes = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic idle_inputs();
    flush = 0; disp_valid = 0; disp_op = 0; disp_offset = 0; disp_base_val = 0;
    disp_base_tag = 0; disp_base_rdy = 1; disp_data_val = 0; disp_data_tag = 0;
    disp_data_rdy = 1; disp_dest_tag = 0; cdb_in_valid = 0; cdb_in_tag = 0;
    cdb_in_value = 0; lsu_ready = 1; lsu_load_data = 0; cdb_grant = 0;
  endtask

  task automatic disp(input logic [2:0] op, input logic [31:0] base, input logic brdy,
                      input logic [3:0] btag, input logic [31:0] off, input logic [31:0] data,
                      input logic [3:0] dest);
    disp_valid = 1; disp_op = op; disp_base_val = base; disp_base_rdy = brdy;
    disp_base_tag = btag; disp_offset = off; disp_data_val = data; disp_data_rdy = 1;
    disp_data_tag = 0; disp_dest_tag = dest;
  endtask

  // Predict this cycle's outputs from the model, compare, then advance the model one clock.
  task automatic cycle();
    bit hv, hrdy, st, exp_req, exp_drdy;
    m_ent_t h, e;
    #1;
    hv = (q.size() > 0);
    if (hv) h = q[0];
    st = hv && h.op[2];
    hrdy = hv && h.brdy && (!h.op[2] || h.drdy);
    exp_req = !m_wait && hrdy && lsu_ready && !flush;
    exp_drdy = (q.size() < DEPTH) && !flush;
    chk("count", 32'(count), 32'(q.size()));
    chk("disp_ready", 32'(disp_ready), 32'(exp_drdy));
    chk("mem_req", 32'(lsu_mem_req), 32'(exp_req));
    if (exp_req) begin
      chk("base_addr", lsu_base_addr, h.base);
      chk("offset", lsu_offset, h.off);
      chk("mem_op", 32'(lsu_mem_op), 32'(h.op));
      if (st) chk("store_data", lsu_store_data, h.data);
    end
    chk("cdb_req", 32'(cdb_req), 32'(m_wait));
    if (m_wait) begin
      chk("cdb_tag", 32'(cdb_tag), 32'(h.dest));
      chk("cdb_value", cdb_value, m_val);
    end
    if (flush) begin
      q.delete();
      m_wait = 0;
    end else begin
      if (cdb_in_valid)
        foreach (q[i]) begin
          if (!q[i].brdy && q[i].btag == cdb_in_tag) begin q[i].base = cdb_in_value; q[i].brdy = 1; end
          if (!q[i].drdy && q[i].dtag == cdb_in_tag) begin q[i].data = cdb_in_value; q[i].drdy = 1; end
        end
      if (exp_req) begin
        if (st) void'(q.pop_front());
        else begin m_wait = 1; m_val = lsu_load_data; end
      end else if (m_wait && cdb_grant) begin
        void'(q.pop_front());
        m_wait = 0;
      end
      if (disp_valid && exp_drdy) begin
        e.op = disp_op; e.off = disp_offset; e.dest = disp_dest_tag;
        e.base = disp_base_val; e.btag = disp_base_tag; e.brdy = disp_base_rdy;
        e.data = disp_data_val; e.dtag = disp_data_tag; e.drdy = disp_data_rdy;
        if (cdb_in_valid && !e.brdy && e.btag == cdb_in_tag) begin e.base = cdb_in_value; e.brdy = 1; end
        if (cdb_in_valid && !e.drdy && e.dtag == cdb_in_tag) begin e.data = cdb_in_value; e.drdy = 1; end
        q.push_back(e);
      end
    end
    @(negedge clk);
  endtask

  initial begin
    idle_inputs();
    rst = 0;
    m_wait = 0; m_val = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1;
    #1;
    chk("rst_count", 32'(count), 0);
    chk("rst_disp_ready", 32'(disp_ready), 1);
    chk("rst_mem_req", 32'(lsu_mem_req), 0);
    chk("rst_cdb_req", 32'(cdb_req), 0);
    chk("rst_cdb_value", cdb_value, 0);
    chk("rst_lsu_base", lsu_base_addr, 0);
    chk("rst_lsu_data", lsu_store_data, 0);

    // ready load: issue next cycle, broadcast the cycle after, grant pops
    disp(3'b010, 32'h100, 1, 0, 4, 0, 3);
    lsu_load_data = 32'hDEADBEEF;
    cycle();
    disp_valid = 0;
    #1;
    chk("ld_req", 32'(lsu_mem_req), 1);
    chk("ld_base", lsu_base_addr, 32'h100);
    chk("ld_off", lsu_offset, 4);
    cycle();
    lsu_load_data = 0;
    #1;
    chk("ld_cdb_req", 32'(cdb_req), 1);
    chk("ld_cdb_tag", 32'(cdb_tag), 3);
    chk("ld_cdb_val", cdb_value, 32'hDEADBEEF);
    chk("ld_wait_no_req", 32'(lsu_mem_req), 0);
    cdb_grant = 1;
    cycle();
    cdb_grant = 0;
    #1;
    chk("ld_popped", 32'(count), 0);

    // store waiting on base tag 5
    disp(3'b100, 0, 0, 5, 8, 32'h55, 0);
    cycle();
    disp_valid = 0;
    #1;
    chk("st_wait", 32'(lsu_mem_req), 0);
    cycle();
    cdb_in_valid = 1; cdb_in_tag = 5; cdb_in_value = 32'h200;
    #1;
    chk("st_capture_cycle", 32'(lsu_mem_req), 0);
    cycle();
    cdb_in_valid = 0;
    #1;
    chk("st_req", 32'(lsu_mem_req), 1);
    chk("st_base", lsu_base_addr, 32'h200);
    chk("st_op2", 32'(lsu_mem_op[2]), 1);
    cycle();
    chk("st_popped", 32'(count), 0);

    // dispatch and CDB in the same cycle
    disp(3'b000, 0, 0, 7, 0, 0, 9);
    cdb_in_valid = 1; cdb_in_tag = 7; cdb_in_value = 32'h40;
    cycle();
    disp_valid = 0; cdb_in_valid = 0;
    #1;
    chk("fwd_req", 32'(lsu_mem_req), 1);
    chk("fwd_base", lsu_base_addr, 32'h40);
    cycle();
    cdb_grant = 1;
    cycle();
    cdb_grant = 0;

    // fill with LSU stalled, fifth dispatch refused, drain in order across the wrap
    lsu_ready = 0;
    for (int i = 0; i < 5; i++) begin
      disp(3'b101, 32'h1000 + i, 1, 0, 0, 32'hA0 + i, 0);
      cycle();
    end
    disp_valid = 0;
    #1;
    chk("full_count", 32'(count), 4);
    chk("full_disp_ready", 32'(disp_ready), 0);
    lsu_ready = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("drain_base", lsu_base_addr, 32'h1000 + i);
      cycle();
    end
    chk("drain_empty", 32'(count), 0);

    // flush with a load stuck in WAIT_CDB; grant and dispatch in the flush cycle are ignored
    disp(3'b011, 32'h300, 1, 0, 0, 0, 6);
    lsu_load_data = 32'h12345678;
    cycle();
    disp_valid = 0;
    cycle();
    cycle();
    #1;
    chk("fl_waiting", 32'(cdb_req), 1);
    flush = 1; cdb_grant = 1;
    disp(3'b100, 32'h9, 1, 0, 0, 0, 0);
    #1;
    chk("fl_no_req", 32'(lsu_mem_req), 0);
    chk("fl_no_disp", 32'(disp_ready), 0);
    cycle();
    idle_inputs();
    #1;
    chk("fl_cdb_req", 32'(cdb_req), 0);
    chk("fl_count", 32'(count), 0);
    cycle();

    for (int n = 0; n < 3000; n++) begin
      flush = ($urandom_range(0, 39) == 0);
      disp_valid = $urandom_range(0, 1);
      disp_op = 3'($urandom);
      disp_offset = $urandom;
      disp_base_val = $urandom;
      disp_base_rdy = ($urandom_range(0, 2) != 0);
      disp_base_tag = 4'($urandom_range(0, 7));
      disp_data_val = $urandom;
      disp_data_rdy = ($urandom_range(0, 2) != 0);
      disp_data_tag = 4'($urandom_range(0, 7));
      disp_dest_tag = 4'($urandom);
      cdb_in_valid = $urandom_range(0, 1);
      cdb_in_tag = 4'($urandom_range(0, 7));
      cdb_in_value = $urandom;
      lsu_ready = ($urandom_range(0, 3) != 0);
      lsu_load_data = $urandom;
      cdb_grant = $urandom_range(0, 1);
      cycle();
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
